// File: rtl/alu_pkg.sv
// Shared ALU definitions: condition codes, NZCV bit positions and the
// result-stage buffer states.
package alu_pkg;

   typedef enum logic [3:0] {
      COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_CS = 4'd2,  COND_CC = 4'd3,
      COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7,
      COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11,
      COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14, COND_NV = 4'd15
   } cond_e;

   localparam int unsigned NZCV_N = 3;
   localparam int unsigned NZCV_Z = 2;
   localparam int unsigned NZCV_C = 1;
   localparam int unsigned NZCV_V = 0;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_e;

endpackage

// File: rtl/alu_result_stage_cond_eval.sv
// Combinational condition-code evaluator against a packed {N,Z,C,V} word;
// shared with the branch unit.
module cond_eval
   import alu_pkg::*;
(
   input  logic [3:0] nzcv,
   input  logic [3:0] cond,
   output logic       cond_true
);

   logic n, z, c, v;

   assign n = nzcv[NZCV_N];
   assign z = nzcv[NZCV_Z];
   assign c = nzcv[NZCV_C];
   assign v = nzcv[NZCV_V];

   always_comb begin
      cond_true = 1'b0;
      case (cond_e'(cond))
         COND_EQ: cond_true = z;
         COND_NE: cond_true = ~z;
         COND_CS: cond_true = c;
         COND_CC: cond_true = ~c;
         COND_MI: cond_true = n;
         COND_PL: cond_true = ~n;
         COND_VS: cond_true = v;
         COND_VC: cond_true = ~v;
         COND_HI: cond_true = c & ~z;
         COND_LS: cond_true = ~c | z;
         COND_GE: cond_true = (n == v);
         COND_LT: cond_true = (n != v);
         COND_GT: cond_true = ~z & (n == v);
         COND_LE: cond_true = z | (n != v);
         COND_AL: cond_true = 1'b1;
         COND_NV: cond_true = 1'b0;
         default: cond_true = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: 2-entry skid buffer toward writeback plus the
// architectural NZCV register and condition evaluation.
module alu_result_stage
   import alu_pkg::*;
#(
   parameter int unsigned BITS     = 8,
   parameter int unsigned REG_BITS = 4
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [BITS-1:0]     bus_s_i,
   input  logic                flag_c_i,
   input  logic                flag_n_i,
   input  logic                flag_v_i,
   input  logic                flag_z_i,
   input  logic [REG_BITS-1:0] rd_i,
   input  logic                set_flags_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [BITS-1:0]     result_o,
   output logic [REG_BITS-1:0] rd_o,
   output logic [3:0]          nzcv_o,
   input  logic [3:0]          cond_i,
   output logic                cond_true_o
);

   state_e              state_q;
   logic [BITS-1:0]     head_data_q, skid_data_q;
   logic [REG_BITS-1:0] head_rd_q, skid_rd_q;
   logic [3:0]          nzcv_q;
   logic                accept, pop;

   assign in_ready_o  = (state_q != ST_TWO) & rst_n_i;
   assign out_valid_o = (state_q != ST_EMPTY);
   assign accept      = in_valid_i & in_ready_o;
   assign pop         = out_valid_o & out_ready_i;

   assign result_o = head_data_q;
   assign rd_o     = head_rd_q;
   assign nzcv_o   = nzcv_q;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q     <= ST_EMPTY;
         head_data_q <= '0;
         head_rd_q   <= '0;
         skid_data_q <= '0;
         skid_rd_q   <= '0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  head_data_q <= bus_s_i;
                  head_rd_q   <= rd_i;
                  state_q     <= ST_ONE;
               end
            end
            ST_ONE: begin
               // Accept with pop replaces the head; accept alone parks in skid.
               if (accept && pop) begin
                  head_data_q <= bus_s_i;
                  head_rd_q   <= rd_i;
               end else if (accept) begin
                  skid_data_q <= bus_s_i;
                  skid_rd_q   <= rd_i;
                  state_q     <= ST_TWO;
               end else if (pop) begin
                  state_q     <= ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (pop) begin
                  head_data_q <= skid_data_q;
                  head_rd_q   <= skid_rd_q;
                  state_q     <= ST_ONE;
               end
            end
            default: state_q <= ST_EMPTY;
         endcase
      end
   end

   // Flags commit on acceptance, independent of when writeback drains the entry.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         nzcv_q <= '0;
      end else if (accept && set_flags_i) begin
         nzcv_q <= {flag_n_i, flag_z_i, flag_c_i, flag_v_i};
      end
   end

   cond_eval u_cond_eval (
      .nzcv      (nzcv_q),
      .cond      (cond_i),
      .cond_true (cond_true_o)
   );

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage.
module tb_alu_result_stage;

   logic       clk_i = 1'b0;
   logic       rst_n_i;
   logic       in_valid_i;
   logic       in_ready_o;
   logic [7:0] bus_s_i;
   logic       flag_c_i, flag_n_i, flag_v_i, flag_z_i;
   logic [3:0] rd_i;
   logic       set_flags_i;
   logic       out_valid_o;
   logic       out_ready_i;
   logic [7:0] result_o;
   logic [3:0] rd_o;
   logic [3:0] nzcv_o;
   logic [3:0] cond_i;
   logic       cond_true_o;

   int checks = 0;
   int errors = 0;

   alu_result_stage #(.BITS(8), .REG_BITS(4)) dut (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .bus_s_i     (bus_s_i),
      .flag_c_i    (flag_c_i),
      .flag_n_i    (flag_n_i),
      .flag_v_i    (flag_v_i),
      .flag_z_i    (flag_z_i),
      .rd_i        (rd_i),
      .set_flags_i (set_flags_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .result_o    (result_o),
      .rd_o        (rd_o),
      .nzcv_o      (nzcv_o),
      .cond_i      (cond_i),
      .cond_true_o (cond_true_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic [3:0] r,
                        input logic sf, input logic n, input logic z,
                        input logic c, input logic vf);
      in_valid_i  = v;
      bus_s_i     = d;
      rd_i        = r;
      set_flags_i = sf;
      flag_n_i    = n;
      flag_z_i    = z;
      flag_c_i    = c;
      flag_v_i    = vf;
   endtask

   task automatic test_reset();
      rst_n_i = 1'b0;
      out_ready_i = 1'b0;
      cond_i = 4'd0;
      drive(1'b1, 8'hFF, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      step();
      step();
      checks++;
      if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid_o); end
      checks++;
      if (result_o !== 8'h00) begin errors++; $display("FAIL reset_result got %h exp 00", result_o); end
      checks++;
      if (rd_o !== 4'h0) begin errors++; $display("FAIL reset_rd got %h exp 0", rd_o); end
      checks++;
      if (nzcv_o !== 4'b0000) begin errors++; $display("FAIL reset_nzcv got %b exp 0000", nzcv_o); end
      checks++;
      if (in_ready_o !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready_o); end
      drive(1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n_i = 1'b1;
      #1;
      checks++;
      if (in_ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready_o); end
   endtask

   task automatic test_single();
      out_ready_i = 1'b1;
      drive(1'b1, 8'hA5, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      step();
      drive(1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cond_i = 4'd2;
      #1;
      checks++;
      if (out_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", out_valid_o); end
      checks++;
      if (result_o !== 8'hA5) begin errors++; $display("FAIL single_result got %h exp a5", result_o); end
      checks++;
      if (rd_o !== 4'd3) begin errors++; $display("FAIL single_rd got %h exp 3", rd_o); end
      checks++;
      if (nzcv_o !== 4'b1010) begin errors++; $display("FAIL single_nzcv got %b exp 1010", nzcv_o); end
      checks++;
      if (cond_true_o !== 1'b1) begin errors++; $display("FAIL single_cond_cs got %b exp 1", cond_true_o); end
      step();
      checks++;
      if (out_valid_o !== 1'b0) begin errors++; $display("FAIL single_drain got %b exp 0", out_valid_o); end
   endtask

   task automatic test_backpressure();
      out_ready_i = 1'b0;
      drive(1'b1, 8'h01, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      checks++;
      if (in_ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_one got %b exp 1", in_ready_o); end
      bus_s_i = 8'h02; rd_i = 4'd2;
      step();
      checks++;
      if (in_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready_two got %b exp 0", in_ready_o); end
      bus_s_i = 8'h03; rd_i = 4'd3;
      step();
      checks++;
      if (result_o !== 8'h01 || rd_o !== 4'd1) begin errors++; $display("FAIL bp_hold got %h/%h exp 01/1", result_o, rd_o); end
      in_valid_i = 1'b0;
      out_ready_i = 1'b1;
      #1;
      checks++;
      if (out_valid_o !== 1'b1 || result_o !== 8'h01) begin errors++; $display("FAIL bp_out1 got %b/%h exp 1/01", out_valid_o, result_o); end
      step();
      checks++;
      if (out_valid_o !== 1'b1 || result_o !== 8'h02 || rd_o !== 4'd2) begin errors++; $display("FAIL bp_out2 got %b/%h/%h exp 1/02/2", out_valid_o, result_o, rd_o); end
      step();
      checks++;
      if (out_valid_o !== 1'b0) begin errors++; $display("FAIL bp_empty got %b exp 0", out_valid_o); end
   endtask

   task automatic test_streaming();
      logic [7:0] exp;
      out_ready_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
         exp = 8'h10 + 8'(i);
         drive(1'b1, exp, 4'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         step();
         checks++;
         if (out_valid_o !== 1'b1 || result_o !== exp || rd_o !== 4'(i) || in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL stream_%0d got v=%b d=%h rd=%h rdy=%b exp 1/%h/%h/1", i, out_valid_o, result_o, rd_o, in_ready_o, exp, 4'(i));
         end
      end
      in_valid_i = 1'b0;
      step();
      checks++;
      if (out_valid_o !== 1'b0) begin errors++; $display("FAIL stream_drain got %b exp 0", out_valid_o); end
   endtask

   task automatic test_flag_gating();
      logic [3:0] codes [4] = '{4'd0, 4'd1, 4'd15, 4'd14};
      logic       exps  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      out_ready_i = 1'b1;
      drive(1'b1, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b1, 8'h00, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      in_valid_i = 1'b0;
      checks++;
      if (nzcv_o !== 4'b0000) begin errors++; $display("FAIL gate_nzcv got %b exp 0000", nzcv_o); end
      for (int i = 0; i < 4; i++) begin
         cond_i = codes[i];
         #1;
         checks++;
         if (cond_true_o !== exps[i]) begin errors++; $display("FAIL gate_cond_%0d got %b exp %b", codes[i], cond_true_o, exps[i]); end
      end
      step();
   endtask

   task automatic test_signed();
      logic [3:0] codes [4] = '{4'd11, 4'd10, 4'd12, 4'd13};
      logic       exps  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      out_ready_i = 1'b1;
      drive(1'b1, 8'h80, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      in_valid_i = 1'b0;
      checks++;
      if (nzcv_o !== 4'b1000) begin errors++; $display("FAIL signed_nzcv got %b exp 1000", nzcv_o); end
      for (int i = 0; i < 4; i++) begin
         cond_i = codes[i];
         #1;
         checks++;
         if (cond_true_o !== exps[i]) begin errors++; $display("FAIL signed_cond_%0d got %b exp %b", codes[i], cond_true_o, exps[i]); end
      end
      drive(1'b1, 8'h00, 4'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      step();
      in_valid_i = 1'b0;
      checks++;
      if (nzcv_o !== 4'b0110) begin errors++; $display("FAIL zc_nzcv got %b exp 0110", nzcv_o); end
      cond_i = 4'd8;
      #1;
      checks++;
      if (cond_true_o !== 1'b0) begin errors++; $display("FAIL cond_hi got %b exp 0", cond_true_o); end
      cond_i = 4'd9;
      #1;
      checks++;
      if (cond_true_o !== 1'b1) begin errors++; $display("FAIL cond_ls got %b exp 1", cond_true_o); end
      step();
   endtask

   task automatic test_reset_mid();
      out_ready_i = 1'b0;
      drive(1'b1, 8'hAA, 4'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      step();
      bus_s_i = 8'hBB; rd_i = 4'd8;
      step();
      in_valid_i = 1'b0;
      checks++;
      if (in_ready_o !== 1'b0 || nzcv_o !== 4'b1011) begin errors++; $display("FAIL mid_full got rdy=%b nzcv=%b exp 0/1011", in_ready_o, nzcv_o); end
      rst_n_i = 1'b0;
      #1;
      checks++;
      if (in_ready_o !== 1'b0) begin errors++; $display("FAIL mid_ready_in_reset got %b exp 0", in_ready_o); end
      step();
      checks++;
      if (out_valid_o !== 1'b0 || nzcv_o !== 4'b0000 || result_o !== 8'h00) begin
         errors++; $display("FAIL mid_reset got v=%b nzcv=%b d=%h exp 0/0000/00", out_valid_o, nzcv_o, result_o);
      end
      rst_n_i = 1'b1;
      #1;
      checks++;
      if (in_ready_o !== 1'b1) begin errors++; $display("FAIL mid_ready_after got %b exp 1", in_ready_o); end
      out_ready_i = 1'b1;
      step();
      checks++;
      if (out_valid_o !== 1'b0 || result_o !== 8'h00) begin errors++; $display("FAIL mid_stale got v=%b d=%h exp 0/00", out_valid_o, result_o); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_streaming();
      test_flag_gating();
      test_signed();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
